// File: rtl/sram_port_arbiter.sv
// Two-master arbiter for the sram read/write port: round-robin with a bounded burst, or fixed
// M0 priority when SRAM_ARB_FIXED_PRIO_EN is defined. Read data returns one cycle after grant.
module sram_port_arbiter #(
  parameter int unsigned AW        = 13,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW/8-1:0] m0_byteen_i,
  input  logic [DW-1:0]   m0_wdata_i,
  output logic            m0_gnt_o,
  output logic            m0_rvalid_o,
  output logic [DW-1:0]   m0_rdata_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW/8-1:0] m1_byteen_i,
  input  logic [DW-1:0]   m1_wdata_i,
  output logic            m1_gnt_o,
  output logic            m1_rvalid_o,
  output logic [DW-1:0]   m1_rdata_o,
  output logic [AW-1:0]   sram_addr_o,
  output logic [DW/8-1:0] sram_byteen_o,
  output logic [DW-1:0]   sram_data_o,
  output logic            sram_wren_o,
  input  logic [DW-1:0]   sram_q_i
);

  localparam int unsigned BW = DW / 8;

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e          state_q, state_d;
  logic            last_owner_q, last_owner_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   byteen_q, byteen_d;
  logic [DW-1:0]   data_q, data_d;
  logic            rvalid_q, rvalid_d;
  logic            rd_owner_q, rd_owner_d;

  logic            any_req;
  logic            win;
  logic            issue;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [BW-1:0]   sel_byteen;
  logic [DW-1:0]   sel_wdata;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);
`endif

  assign any_req = m0_req_i | m1_req_i;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    win          = 1'b0;
    if (m0_req_i ^ m1_req_i) begin
      win = m1_req_i;
    end else if (any_req) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      unique case (state_q)
        StOwn0:  win = (burst_cnt_q >= MaxBurst);
        StOwn1:  win = (burst_cnt_q <  MaxBurst);
        default: win = ~last_owner_q;
      endcase
`endif
    end

    if (!any_req) begin
      state_d     = StIdle;
      burst_cnt_d = '0;
    end else begin
      state_d      = win ? StOwn1 : StOwn0;
      last_owner_d = win;
      // Owner change (including leaving idle) restarts the burst; count only contested grants.
      if (state_d != state_q) begin
        burst_cnt_d = 4'd1;
      end else if ((win ? m0_req_i : m1_req_i) && (burst_cnt_q != 4'hF)) begin
        burst_cnt_d = burst_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    sel_we     = win ? m1_we_i     : m0_we_i;
    sel_addr   = win ? m1_addr_i   : m0_addr_i;
    sel_byteen = win ? m1_byteen_i : m0_byteen_i;
    sel_wdata  = win ? m1_wdata_i  : m0_wdata_i;

    addr_d     = any_req ? sel_addr   : addr_q;
    byteen_d   = any_req ? sel_byteen : byteen_q;
    data_d     = any_req ? sel_wdata  : data_q;
    rvalid_d   = any_req & ~sel_we;
    rd_owner_d = win;
  end

  // Reset only gates the outputs so no grant or write can escape while rst_ni is low.
  assign issue         = any_req & rst_ni;
  assign m0_gnt_o      = issue & ~win;
  assign m1_gnt_o      = issue & win;
  assign sram_wren_o   = issue & sel_we;
  assign sram_addr_o   = issue ? sel_addr   : addr_q;
  assign sram_byteen_o = issue ? sel_byteen : byteen_q;
  assign sram_data_o   = issue ? sel_wdata  : data_q;

  assign m0_rvalid_o = rvalid_q & ~rd_owner_q;
  assign m1_rvalid_o = rvalid_q & rd_owner_q;
  assign m0_rdata_o  = sram_q_i;
  assign m1_rdata_o  = sram_q_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
      addr_q       <= '0;
      byteen_q     <= '0;
      data_q       <= '0;
      rvalid_q     <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      addr_q       <= addr_d;
      byteen_q     <= byteen_d;
      data_q       <= data_d;
      rvalid_q     <= rvalid_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: behavioural sram, arbitration model, read-return queue.
module tb_sram_port_arbiter;

  localparam int MAXB = 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        req    [2];
  logic        we_c   [2];
  logic [12:0] addr_c [2];
  logic [3:0]  be_c   [2];
  logic [31:0] wd_c   [2];

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, sram_wren;
  logic [31:0] m0_rdata, m1_rdata, sram_data, sram_q;
  logic [12:0] sram_addr;
  logic [3:0]  sram_byteen;

  sram_port_arbiter #(.AW(13), .DW(32), .MAX_BURST(MAXB)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .m0_req_i     (req[0]),
    .m0_we_i      (we_c[0]),
    .m0_addr_i    (addr_c[0]),
    .m0_byteen_i  (be_c[0]),
    .m0_wdata_i   (wd_c[0]),
    .m0_gnt_o     (m0_gnt),
    .m0_rvalid_o  (m0_rvalid),
    .m0_rdata_o   (m0_rdata),
    .m1_req_i     (req[1]),
    .m1_we_i      (we_c[1]),
    .m1_addr_i    (addr_c[1]),
    .m1_byteen_i  (be_c[1]),
    .m1_wdata_i   (wd_c[1]),
    .m1_gnt_o     (m1_gnt),
    .m1_rvalid_o  (m1_rvalid),
    .m1_rdata_o   (m1_rdata),
    .sram_addr_o  (sram_addr),
    .sram_byteen_o(sram_byteen),
    .sram_data_o  (sram_data),
    .sram_wren_o  (sram_wren),
    .sram_q_i     (sram_q)
  );

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Behavioural 8K x 32 sram port: registered read, byte-masked write.
  logic [31:0] mem [0:8191];
  always @(posedge clk_i) begin
    if (sram_wren) mem[sram_addr] <= merge(mem[sram_addr], sram_data, sram_byteen);
    sram_q <= mem[sram_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model state
  logic [31:0] ref_mem [0:8191];
  int          m_owner, m_last, m_run;
  logic [12:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_data;

  typedef struct {
    int          due;
    logic        m;
    logic [31:0] d;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 1;
    m_run   = 0;
    m_addr  = '0;
    m_be    = '0;
    m_data  = '0;
  endfunction

  function automatic int model_pick();
    if (!req[0] && !req[1]) return -1;
    if (req[0] != req[1]) return req[0] ? 0 : 1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    return 0;
`else
    if (m_owner < 0) return 1 - m_last;
    return (m_run < MAXB) ? m_owner : 1 - m_owner;
`endif
  endfunction

  function automatic void model_update(int win);
    if (win < 0) begin
      m_owner = -1;
      m_run   = 0;
    end else begin
      if (win != m_owner) m_run = 1;
      else if (req[1-win]) m_run++;
      m_owner = win;
      m_last  = win;
    end
  endfunction

  task automatic set_cmd(int m, logic we, logic [12:0] a, logic [3:0] be, logic [31:0] d);
    req[m]    = 1'b1;
    we_c[m]   = we;
    addr_c[m] = a;
    be_c[m]   = be;
    wd_c[m]   = d;
  endtask

  task automatic clear_reqs();
    req[0] = 1'b0;
    req[1] = 1'b0;
  endtask

  // One cycle: check the issue side at negedge, advance the model, push expected read beats.
  task automatic step(input bit rst_now, output int dwin, output logic rv0, output logic rv1,
                      output logic [31:0] rd0, output logic [31:0] rd1);
    int win;
    @(negedge clk_i);
    rv0  = m0_rvalid;
    rv1  = m1_rvalid;
    rd0  = m0_rdata;
    rd1  = m1_rdata;
    dwin = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
    win  = model_pick();
    chk("gnt0", {31'b0, m0_gnt}, {31'b0, win == 0});
    chk("gnt1", {31'b0, m1_gnt}, {31'b0, win == 1});
    if (win >= 0) begin
      chk("sram_addr", {19'b0, sram_addr}, {19'b0, addr_c[win]});
      chk("sram_wren", {31'b0, sram_wren}, {31'b0, we_c[win]});
      if (we_c[win]) begin
        chk("sram_data", sram_data, wd_c[win]);
        chk("sram_byteen", {28'b0, sram_byteen}, {28'b0, be_c[win]});
      end
    end else begin
      chk("idle_wren", {31'b0, sram_wren}, 32'd0);
      chk("hold_addr", {19'b0, sram_addr}, {19'b0, m_addr});
      chk("hold_byteen", {28'b0, sram_byteen}, {28'b0, m_be});
      chk("hold_data", sram_data, m_data);
    end
    if (rst_now) begin
      #1;
      rst_ni = 1'b0;
      sb_q.delete();
      model_reset();
      clear_reqs();
    end else begin
      model_update(win);
      if (win >= 0) begin
        m_addr = addr_c[win];
        m_be   = be_c[win];
        m_data = wd_c[win];
        if (we_c[win]) ref_mem[addr_c[win]] = merge(ref_mem[addr_c[win]], wd_c[win], be_c[win]);
        else sb_q.push_back('{due: cyc + 1, m: (win == 1), d: ref_mem[addr_c[win]]});
      end
    end
    @(posedge clk_i);
    #1;
    if (!rst_now && win >= 0) req[win] = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    sb_q.delete();
    model_reset();
    set_cmd(0, 1'b1, 13'd3, 4'hF, 32'hFFFF_FFFF);
    set_cmd(1, 1'b1, 13'd4, 4'hF, 32'hFFFF_FFFF);
    repeat (2) begin
      @(negedge clk_i);
      chk("rst_gnt0", {31'b0, m0_gnt}, 32'd0);
      chk("rst_gnt1", {31'b0, m1_gnt}, 32'd0);
      chk("rst_wren", {31'b0, sram_wren}, 32'd0);
      chk("rst_addr", {19'b0, sram_addr}, 32'd0);
    end
    clear_reqs();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every cycle, the read-return side must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e = sb_q.pop_front();
      chk("rvalid_owner", {31'b0, mon_e.m ? m1_rvalid : m0_rvalid}, 32'd1);
      chk("rvalid_other", {31'b0, mon_e.m ? m0_rvalid : m1_rvalid}, 32'd0);
      chk("rdata", mon_e.m ? m1_rdata : m0_rdata, mon_e.d);
    end else begin
      chk("rvalid0_quiet", {31'b0, m0_rvalid}, 32'd0);
      chk("rvalid1_quiet", {31'b0, m1_rvalid}, 32'd0);
    end
  end

  initial begin
    int          dwin;
    logic        rv0, rv1;
    logic [31:0] rd0, rd1;
    logic [31:0] keep;
    int          exp_w;

    for (int i = 0; i < 8192; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; we_c[m] = 1'b0; addr_c[m] = '0; be_c[m] = '0; wd_c[m] = '0;
    end
    model_reset();
    @(posedge clk_i);
    #1;

    // Reset, then idle cycles
    do_reset();
    repeat (2) step(1'b0, dwin, rv0, rv1, rd0, rd1);

    // M0 write then read of address 0
    set_cmd(0, 1'b1, 13'd0, 4'hF, 32'h1234_5678);
    step(1'b0, dwin, rv0, rv1, rd0, rd1);
    set_cmd(0, 1'b0, 13'd0, 4'h0, 32'h0);
    step(1'b0, dwin, rv0, rv1, rd0, rd1);
    chk("t2_gnt", dwin, 0);
    step(1'b0, dwin, rv0, rv1, rd0, rd1);
    chk("t2_rvalid0", {31'b0, rv0}, 32'd1);
    chk("t2_rvalid1", {31'b0, rv1}, 32'd0);
    chk("t2_rdata", rd0, 32'h1234_5678);

    // M1 partial-lane writes
    set_cmd(1, 1'b1, 13'd0, 4'b1100, 32'h9876_DEAD);
    step(1'b0, dwin, rv0, rv1, rd0, rd1);
    set_cmd(1, 1'b0, 13'd0, 4'h0, 32'h0);
    step(1'b0, dwin, rv0, rv1, rd0, rd1);
    step(1'b0, dwin, rv0, rv1, rd0, rd1);
    chk("t3a_rvalid1", {31'b0, rv1}, 32'd1);
    chk("t3a_rdata", rd1, 32'h9876_5678);
    set_cmd(1, 1'b1, 13'd0, 4'b0011, 32'hDEAD_5432);
    step(1'b0, dwin, rv0, rv1, rd0, rd1);
    set_cmd(1, 1'b0, 13'd0, 4'h0, 32'h0);
    step(1'b0, dwin, rv0, rv1, rd0, rd1);
    step(1'b0, dwin, rv0, rv1, rd0, rd1);
    chk("t3b_rdata", rd1, 32'h9876_5432);

    // Both masters reading continuously from a fresh reset
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (!req[0]) set_cmd(0, 1'b0, 13'(k), 4'h0, 32'h0);
      if (!req[1]) set_cmd(1, 1'b0, 13'(k + 100), 4'h0, 32'h0);
      step(1'b0, dwin, rv0, rv1, rd0, rd1);
`ifdef SRAM_ARB_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = (k / MAXB) % 2;
`endif
      chk("burst_pattern", dwin, exp_w);
    end
    req[0] = 1'b0;
    if (!req[1]) set_cmd(1, 1'b0, 13'd7, 4'h0, 32'h0);
    step(1'b0, dwin, rv0, rv1, rd0, rd1);
    chk("m0_drop_m1_gnt", dwin, 1);
    repeat (2) step(1'b0, dwin, rv0, rv1, rd0, rd1);

    // Reset right after an M1 read grant: no beat returns, no write escapes
    keep = ref_mem[5];
    set_cmd(1, 1'b0, 13'd5, 4'h0, 32'h0);
    step(1'b1, dwin, rv0, rv1, rd0, rd1);
    set_cmd(1, 1'b1, 13'd5, 4'hF, 32'hFFFF_FFFF);
    repeat (3) begin
      @(negedge clk_i);
      chk("t6_rvalid1", {31'b0, m1_rvalid}, 32'd0);
      chk("t6_wren", {31'b0, sram_wren}, 32'd0);
    end
    clear_reqs();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("t6_mem", mem[5], keep);

    // Randomized traffic with withdrawals on a small address window
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m]) begin
          if ($urandom_range(0, 99) < 65)
            set_cmd(m, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), $urandom);
        end else if ($urandom_range(0, 99) < 5) begin
          req[m] = 1'b0;
        end
      end
      step(1'b0, dwin, rv0, rv1, rd0, rd1);
    end
    clear_reqs();
    repeat (3) step(1'b0, dwin, rv0, rv1, rd0, rd1);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
